// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video output path.
//   fetch_state_t : states of the frame-buffer read scheduler
//   WORD_BYTES    : bytes per memory bus word
//   PIX_PER_WORD  : 8-bit pixels carried in one bus word
//   DEF_WIDTH/HEIGHT : default active raster, also used by the output generator
//   clog2_min1    : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        DATA      = 2'd2,
        FRAME_END = 2'd3
    } fetch_state_t;

    localparam int WORD_BYTES   = 4;
    localparam int PIX_PER_WORD = 4;
    localparam int DEF_WIDTH    = 640;
    localparam int DEF_HEIGHT   = 480;

    // A counter for a range of 1 still needs one flop to be a legal vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_out_fetch_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// fetch_addr_gen
// Frame position and buffer selection for the read scheduler.
//   clk, nRST        : clock, asynchronous active-low reset
//   i_load           : latch a new burst start address
//   i_burst_inc      : advance to the next burst of the frame
//   i_burst_clr      : return to the first burst of the frame
//   i_frame_end      : frame boundary; a pending swap is applied here
//   i_swap_req       : back buffer complete (one-cycle pulse)
//   i_fb_base_a/b    : byte base addresses of buffers A and B
//   o_rd_addr        : burst start byte address
//   o_front_sel      : 0 = A displayed, 1 = B displayed
//   o_swap_ack       : one-cycle pulse when a swap is applied
//   o_burst_last     : current burst is the last one of the frame
// ---------------------------------------------------------------------------
module fetch_addr_gen
    import video_pkg::*;
#(
    parameter int BURST_WORDS  = 8,
    parameter int FRAME_BURSTS = 9600
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        i_load,
    input  logic        i_burst_inc,
    input  logic        i_burst_clr,
    input  logic        i_frame_end,
    input  logic        i_swap_req,
    input  logic [31:0] i_fb_base_a,
    input  logic [31:0] i_fb_base_b,
    output logic [31:0] o_rd_addr,
    output logic        o_front_sel,
    output logic        o_swap_ack,
    output logic        o_burst_last
);

    localparam int BIDX_W = clog2_min1(FRAME_BURSTS);
    localparam logic [BIDX_W-1:0] LAST_BURST  = BIDX_W'(FRAME_BURSTS - 1);
    localparam logic [31:0]       BURST_BYTES = 32'(BURST_WORDS * WORD_BYTES);

    logic [BIDX_W-1:0] r_burst_idx;
    logic              r_front_sel;
    logic              r_swap_pending;
    logic              r_swap_ack;
    logic [31:0]       r_rd_addr;

    logic [31:0]       w_base;
    logic [31:0]       w_offset;

    // Bases are sampled only here, so software may rewrite the back buffer
    // base at any time without disturbing a burst in flight.
    assign w_base   = r_front_sel ? i_fb_base_b : i_fb_base_a;
    assign w_offset = 32'(r_burst_idx) * BURST_BYTES;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_burst_idx    <= '0;
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_ack     <= 1'b0;
            r_rd_addr      <= '0;
        end else begin
            r_swap_ack <= i_frame_end & r_swap_pending;
            if (i_frame_end && r_swap_pending) begin
                r_front_sel <= ~r_front_sel;
            end
            // A request arriving in the boundary cycle itself survives the
            // clear and waits for the next frame; repeats collapse into one.
            r_swap_pending <= (r_swap_pending & ~i_frame_end) | i_swap_req;

            if (i_burst_clr) begin
                r_burst_idx <= '0;
            end else if (i_burst_inc) begin
                r_burst_idx <= r_burst_idx + BIDX_W'(1);
            end

            if (i_load) begin
                r_rd_addr <= w_base + w_offset;
            end
        end
    end

    assign o_rd_addr    = r_rd_addr;
    assign o_front_sel  = r_front_sel;
    assign o_swap_ack   = r_swap_ack;
    assign o_burst_last = (r_burst_idx == LAST_BURST);

endmodule

// File: rtl/video_out_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// video_out_fetch_ctrl
// Read-side scheduler for the video output path. Issues fixed-length burst
// reads of the displayed frame buffer and writes the returned words into the
// output pixel FIFO, walking the frame linearly with A/B double buffering.
//
// Handshake: o_rd_req is held with o_rd_addr stable until i_rd_gnt is seen
// high on a clock edge; that edge accepts the burst and o_rd_req drops. Only
// one burst is outstanding; i_rd_valid beats are accepted only while the
// burst is in flight and each one becomes an o_fifo_we one cycle later.
//
//   clk, nRST       : clock, asynchronous active-low reset
//   i_enable        : fetch enable (level)
//   i_fb_base_a/b   : byte base addresses of buffers A and B
//   i_swap_req      : back buffer complete, display it next frame (pulse)
//   o_swap_ack      : swap applied (pulse, coincides with o_frame_done)
//   o_front_sel     : 0 = A displayed, 1 = B displayed
//   o_rd_req/addr   : burst read request and start byte address
//   i_rd_gnt        : request accepted (one cycle)
//   i_rd_valid/data : read data beats
//   i_fifo_free     : free word slots in the output FIFO
//   o_fifo_we/wdata : FIFO write
//   o_frame_done    : pulse after the last word of a frame is written
//   o_dbg_state     : current scheduler state (fetch_state_t encoding)
// ---------------------------------------------------------------------------
module video_out_fetch_ctrl
    import video_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int BURST_WORDS = 8,
    parameter int FREE_W      = 9
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              i_enable,
    input  logic [31:0]       i_fb_base_a,
    input  logic [31:0]       i_fb_base_b,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_front_sel,
    output logic              o_rd_req,
    output logic [31:0]       o_rd_addr,
    input  logic              i_rd_gnt,
    input  logic              i_rd_valid,
    input  logic [31:0]       i_rd_data,
    input  logic [FREE_W-1:0] i_fifo_free,
    output logic              o_fifo_we,
    output logic [31:0]       o_fifo_wdata,
    output logic              o_frame_done,
    output logic [1:0]        o_dbg_state
);

    localparam int FRAME_WORDS  = WIDTH * HEIGHT / PIX_PER_WORD;
    localparam int FRAME_BURSTS = FRAME_WORDS / BURST_WORDS;
    localparam int BEAT_W       = clog2_min1(BURST_WORDS);
    localparam logic [FREE_W-1:0] BURST_FREE = FREE_W'(BURST_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_WORDS - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [BEAT_W-1:0] r_beat;
    logic              r_abort;
    logic              r_fifo_we;
    logic [31:0]       r_fifo_wdata;
    logic              r_frame_done;

    logic              w_load;
    logic              w_burst_inc;
    logic              w_burst_clr;
    logic              w_frame_end;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_abort;
    logic              w_burst_last;

    assign w_beat      = (r_state == DATA) && i_rd_valid;
    assign w_last_beat = w_beat && (r_beat == LAST_BEAT);
    // Enable low at any point of the burst counts, including the final beat.
    assign w_abort     = r_abort | ~i_enable;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_burst_inc  = 1'b0;
        w_burst_clr  = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable && (i_fifo_free >= BURST_FREE)) begin
                    w_next_state = REQ;
                    w_load       = 1'b1;
                end
            end
            REQ: begin
                if (i_rd_gnt) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_last_beat) begin
                    w_next_state = IDLE;
                    if (w_burst_last) begin
                        w_next_state = FRAME_END;
                    end else if (w_abort) begin
                        // Restart at the top of the front frame next time.
                        w_burst_clr = 1'b1;
                    end else begin
                        w_burst_inc = 1'b1;
                    end
                end
            end
            FRAME_END: begin
                w_frame_end  = 1'b1;
                w_burst_clr  = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_abort      <= 1'b0;
            r_fifo_we    <= 1'b0;
            r_fifo_wdata <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_fifo_we    <= w_beat;
            r_frame_done <= w_frame_end;
            if (w_beat) begin
                r_fifo_wdata <= i_rd_data;
                r_beat       <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
            end
            if (r_state == IDLE) begin
                r_abort <= 1'b0;
            end else if (((r_state == REQ) || (r_state == DATA)) && !i_enable) begin
                r_abort <= 1'b1;
            end
        end
    end

    fetch_addr_gen #(
        .BURST_WORDS  (BURST_WORDS),
        .FRAME_BURSTS (FRAME_BURSTS)
    ) u_addr_gen (
        .clk          (clk),
        .nRST         (nRST),
        .i_load       (w_load),
        .i_burst_inc  (w_burst_inc),
        .i_burst_clr  (w_burst_clr),
        .i_frame_end  (w_frame_end),
        .i_swap_req   (i_swap_req),
        .i_fb_base_a  (i_fb_base_a),
        .i_fb_base_b  (i_fb_base_b),
        .o_rd_addr    (o_rd_addr),
        .o_front_sel  (o_front_sel),
        .o_swap_ack   (o_swap_ack),
        .o_burst_last (w_burst_last)
    );

    // Decoded from state so that reset removes the request asynchronously.
    assign o_rd_req     = (r_state == REQ);
    assign o_fifo_we    = r_fifo_we;
    assign o_fifo_wdata = r_fifo_wdata;
    assign o_frame_done = r_frame_done;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_video_out_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_out_fetch_ctrl
// Self-checking bench: 16x2 frame, 4-word bursts (2 bursts per frame).
// ---------------------------------------------------------------------------
module tb_video_out_fetch_ctrl;

    localparam int WIDTH  = 16;
    localparam int HEIGHT = 2;
    localparam int BW     = 4;
    localparam int FREE_W = 9;

    logic              clk = 1'b0;
    logic              nRST = 1'b0;
    logic              enable = 1'b0;
    logic [31:0]       fb_base_a = 32'h0000_1000;
    logic [31:0]       fb_base_b = 32'h0000_8000;
    logic              swap_req = 1'b0;
    logic              swap_ack;
    logic              front_sel;
    logic              rd_req;
    logic [31:0]       rd_addr;
    logic              rd_gnt = 1'b0;
    logic              rd_valid = 1'b0;
    logic [31:0]       rd_data = '0;
    logic [FREE_W-1:0] fifo_free = 9'd16;
    logic              fifo_we;
    logic [31:0]       fifo_wdata;
    logic              frame_done;
    logic [1:0]        dbg_state;

    video_out_fetch_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BURST_WORDS(BW), .FREE_W(FREE_W)
    ) dut (
        .clk          (clk),
        .nRST         (nRST),
        .i_enable     (enable),
        .i_fb_base_a  (fb_base_a),
        .i_fb_base_b  (fb_base_b),
        .i_swap_req   (swap_req),
        .o_swap_ack   (swap_ack),
        .o_front_sel  (front_sel),
        .o_rd_req     (rd_req),
        .o_rd_addr    (rd_addr),
        .i_rd_gnt     (rd_gnt),
        .i_rd_valid   (rd_valid),
        .i_rd_data    (rd_data),
        .i_fifo_free  (fifo_free),
        .o_fifo_we    (fifo_we),
        .o_fifo_wdata (fifo_wdata),
        .o_frame_done (frame_done),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          exp_t[$];
    logic [7:0]  pix = 8'd0;
    int          n_fd = 0;
    int          n_ack = 0;
    int          n_we = 0;
    logic        fd_sel = 1'b0;
    logic        fd_ack = 1'b0;

    // Advance one cycle and observe outputs at the falling edge; every FIFO
    // write is matched against the oldest expected word and its due cycle.
    task automatic step();
        logic [31:0] e;
        int          t;
        @(negedge clk);
        if (fifo_we) begin
            n_we++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_write: unexpected write got=%h expected none", fifo_wdata);
            end else begin
                e = exp_q.pop_front();
                t = exp_t.pop_front();
                if (fifo_wdata !== e) begin
                    errors++;
                    $display("FAIL fifo_wdata: got=%h expected=%h", fifo_wdata, e);
                end
                checks++;
                if (cyc !== t) begin
                    errors++;
                    $display("FAIL fifo_we_latency: write at cycle %0d expected cycle %0d", cyc, t);
                end
            end
        end
        if (frame_done) begin
            n_fd++;
            fd_sel = front_sel;
            fd_ack = swap_ack;
        end
        if (swap_ack) n_ack++;
    endtask

    // ---------------- bus driver ----------------
    // Waits for a request, grants it after gnt_dly cycles and returns 4 beats.
    // drop_at: beat index after which enable is lowered (-1 = never).
    task automatic serve_burst(input int gnt_dly, input int drop_at, input bit swap_at_end,
                               output logic [31:0] addr, output bit timeout,
                               output logic [1:0] st_end, output logic req_after_gnt);
        int n;
        n = 0;
        timeout = 1'b0;
        addr = '0;
        st_end = '0;
        req_after_gnt = 1'b0;
        while (!rd_req && n < 200) begin
            step();
            n++;
        end
        if (!rd_req) begin
            timeout = 1'b1;
            return;
        end
        addr = rd_addr;
        repeat (gnt_dly) step();
        rd_gnt = 1'b1;
        step();
        rd_gnt = 1'b0;
        req_after_gnt = rd_req;
        for (int b = 0; b < BW; b++) begin
            rd_valid = 1'b1;
            rd_data  = {pix + 8'd3, pix + 8'd2, pix + 8'd1, pix};
            pix      = pix + 8'd4;
            exp_q.push_back(rd_data);
            exp_t.push_back(cyc + 1);
            if (b == drop_at) enable = 1'b0;
            step();
        end
        rd_valid = 1'b0;
        rd_data  = '0;
        st_end   = dbg_state;
        if (swap_at_end) swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nRST = 1'b0;
        step();
        step();
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got=%b expected=0", rd_req); end
        checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL reset_fifo_we: got=%b expected=0", fifo_we); end
        checks++; if (fifo_wdata !== 32'h0) begin errors++; $display("FAIL reset_fifo_wdata: got=%h expected=0", fifo_wdata); end
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel: got=%b expected=0", front_sel); end
        checks++; if (swap_ack !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: ack=%b done=%b expected 0 0", swap_ack, frame_done); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got=%0d expected=0", dbg_state); end
        nRST = 1'b1;
        step();
    endtask

    task automatic test_basic_fetch();
        logic [31:0] a;
        bit          to;
        logic [1:0]  st;
        logic        rg;
        fifo_free = 9'd16;
        enable = 1'b1;
        serve_burst(2, -1, 1'b0, a, to, st, rg);
        checks++; if (to) begin errors++; $display("FAIL basic_req0: no rd_req within 200 cycles"); end
        checks++; if (a !== 32'h1000) begin errors++; $display("FAIL basic_addr0: got=%h expected=00001000", a); end
        checks++; if (rg !== 1'b0) begin errors++; $display("FAIL basic_req_drop: rd_req=%b after grant expected=0", rg); end
        serve_burst(2, -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1010 || to) begin errors++; $display("FAIL basic_addr1: got=%h expected=00001010", a); end
        checks++; if (n_fd !== 1) begin errors++; $display("FAIL basic_frame_done: count=%0d expected=1", n_fd); end
        serve_burst($urandom_range(0, 3), -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1000 || to) begin errors++; $display("FAIL basic_wrap_addr: got=%h expected=00001000", a); end
        serve_burst($urandom_range(0, 3), 3, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1010 || to) begin errors++; $display("FAIL basic_addr3: got=%h expected=00001010", a); end
        checks++; if (exp_q.size() != 0 || n_we !== 16) begin errors++; $display("FAIL basic_writes: writes=%0d pending=%0d expected 16 and 0", n_we, exp_q.size()); end
    endtask

    task automatic test_throttle();
        logic [31:0] a;
        bit          to;
        logic [1:0]  st;
        logic        rg;
        int          hi;
        hi = 0;
        fifo_free = 9'd3;
        enable = 1'b1;
        repeat (50) begin
            step();
            if (rd_req) hi++;
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL throttle_hold: rd_req high %0d cycles expected 0", hi); end
        fifo_free = 9'd4;
        step();
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL throttle_release: rd_req=%b expected=1", rd_req); end
        fifo_free = 9'd16;
        serve_burst(1, -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1000 || to) begin errors++; $display("FAIL throttle_addr: got=%h expected=00001000", a); end
        serve_burst(0, 3, 1'b0, a, to, st, rg);
    endtask

    task automatic test_swap();
        logic [31:0] a;
        bit          to;
        logic [1:0]  st;
        logic        rg;
        int          ack0;
        int          fd0;
        ack0 = n_ack;
        fd0  = n_fd;
        enable = 1'b1;
        serve_burst($urandom_range(0, 3), -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1000 || to) begin errors++; $display("FAIL swap_addr0: got=%h expected=00001000", a); end
        swap_req = 1'b1; step(); swap_req = 1'b0;
        repeat (3) step();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        checks++; if (front_sel !== 1'b0 || n_ack !== ack0) begin errors++; $display("FAIL swap_early: front_sel=%b acks=%0d expected 0 and %0d", front_sel, n_ack, ack0); end
        serve_burst(1, -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1010 || to) begin errors++; $display("FAIL swap_addr1: got=%h expected=00001010", a); end
        checks++; if (n_fd !== fd0 + 1 || fd_sel !== 1'b1 || fd_ack !== 1'b1) begin errors++; $display("FAIL swap_apply: frames=%0d sel=%b ack=%b expected %0d 1 1", n_fd, fd_sel, fd_ack, fd0 + 1); end
        serve_burst(1, -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h8000 || to) begin errors++; $display("FAIL swap_addr_b: got=%h expected=00008000", a); end
        serve_burst(1, 3, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h8010 || to) begin errors++; $display("FAIL swap_addr_b1: got=%h expected=00008010", a); end
        checks++; if (n_ack !== ack0 + 1 || front_sel !== 1'b1 || fd_ack !== 1'b0) begin errors++; $display("FAIL swap_single: acks=%0d sel=%b expected %0d and 1", n_ack, front_sel, ack0 + 1); end
    endtask

    task automatic test_swap_boundary();
        logic [31:0] a;
        bit          to;
        logic [1:0]  st;
        logic        rg;
        enable = 1'b1;
        serve_burst(0, -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h8000 || to) begin errors++; $display("FAIL bound_addr0: got=%h expected=00008000", a); end
        serve_burst(0, -1, 1'b1, a, to, st, rg);
        checks++; if (st !== 2'd3) begin errors++; $display("FAIL bound_state: swap_req driven in state %0d expected 3", st); end
        checks++; if (fd_ack !== 1'b0 || front_sel !== 1'b1) begin errors++; $display("FAIL bound_not_applied: ack=%b sel=%b expected 0 1", fd_ack, front_sel); end
        serve_burst(2, -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h8000 || to) begin errors++; $display("FAIL bound_addr2: got=%h expected=00008000", a); end
        serve_burst(2, 3, 1'b0, a, to, st, rg);
        checks++; if (fd_ack !== 1'b1 || fd_sel !== 1'b0 || front_sel !== 1'b0) begin errors++; $display("FAIL bound_applied: ack=%b sel=%b expected 1 0", fd_ack, fd_sel); end
    endtask

    task automatic test_enable_drop();
        logic [31:0] a;
        bit          to;
        logic [1:0]  st;
        logic        rg;
        int          fd0;
        fd0 = n_fd;
        enable = 1'b1;
        serve_burst(1, 1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1000 || to) begin errors++; $display("FAIL drop_addr0: got=%h expected=00001000", a); end
        repeat (3) step();
        checks++; if (dbg_state !== 2'd0 || rd_req !== 1'b0) begin errors++; $display("FAIL drop_idle: state=%0d rd_req=%b expected 0 0", dbg_state, rd_req); end
        checks++; if (exp_q.size() != 0 || n_fd !== fd0) begin errors++; $display("FAIL drop_beats: pending=%0d frames=%0d expected 0 %0d", exp_q.size(), n_fd, fd0); end
        enable = 1'b1;
        serve_burst(1, -1, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1000 || to) begin errors++; $display("FAIL drop_restart: got=%h expected=00001000", a); end
        swap_req = 1'b1; step(); swap_req = 1'b0;
        serve_burst(1, 3, 1'b0, a, to, st, rg);
        checks++; if (a !== 32'h1010 || front_sel !== 1'b1) begin errors++; $display("FAIL drop_tail: addr=%h sel=%b expected 00001010 1", a, front_sel); end
    endtask

    task automatic test_async_reset();
        int n;
        int we0;
        n = 0;
        enable = 1'b1;
        while (!rd_req && n < 200) begin
            step();
            n++;
        end
        checks++; if (rd_req !== 1'b1 || rd_addr !== 32'h8000) begin errors++; $display("FAIL rst_req: rd_req=%b addr=%h expected 1 00008000", rd_req, rd_addr); end
        rd_gnt = 1'b1; step(); rd_gnt = 1'b0;
        rd_valid = 1'b1;
        rd_data  = 32'hdead_beef;
        exp_q.push_back(rd_data);
        exp_t.push_back(cyc + 1);
        step();
        rd_valid = 1'b0;
        checks++; if (fifo_we !== 1'b1 || dbg_state !== 2'd2) begin errors++; $display("FAIL rst_pre: fifo_we=%b state=%0d expected 1 2", fifo_we, dbg_state); end
        #2 nRST = 1'b0;
        #1;
        checks++; if (rd_req !== 1'b0 || fifo_we !== 1'b0) begin errors++; $display("FAIL rst_async_out: rd_req=%b fifo_we=%b expected 0 0", rd_req, fifo_we); end
        checks++; if (front_sel !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rst_async_state: sel=%b state=%0d expected 0 0", front_sel, dbg_state); end
        enable = 1'b0;
        step();
        nRST = 1'b1;
        we0 = n_we;
        repeat (3) begin
            rd_valid = 1'b1;
            rd_data  = $urandom;
            step();
        end
        rd_valid = 1'b0;
        step();
        checks++; if (n_we !== we0 || exp_q.size() != 0) begin errors++; $display("FAIL rst_stray: writes=%0d expected %0d", n_we, we0); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_throttle();
        test_swap();
        test_swap_boundary();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
